// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional bne support in the BEQ state is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BRCH = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_take;
  logic       w_br_ok;

`ifdef MULTICYCLE_BNE_EN
  assign w_take  = funct3[0] ? ~zero : zero;
  assign w_br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
  logic w_unused_funct3;
  assign w_unused_funct3 = ^funct3;
  assign w_take  = zero;
  assign w_br_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RESET_STATE;
    else          r_state <= w_next;
  end

  always_comb begin
    unique case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BRCH: imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    w_next      = FETCH;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        w_pc_update = mem_ready;
        w_next      = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECUTER;
          OP_I:         w_next = EXECUTEI;
          OP_JAL:       w_next = JAL;
          OP_BRCH: begin
            w_next     = w_br_ok ? BEQ : FETCH;
            illegal_op = ~w_br_ok;
          end
          default:      illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        w_next  = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        w_next    = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write = w_pc_update | (w_branch & w_take);
  assign state    = r_state;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle RV32I datapath. Sequences fetch, decode, execute, memory and writeback over several cycles, and owns all datapath enables and mux selects.
- Produces the 2-bit ALUOp consumed by the existing ALU decoder.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Stalls on a memory ready handshake so the same block serves single-cycle and wait-stated memories.

Parameters:
- RESET_STATE, 4'd0, encoding of FETCH, the state entered on reset. State encodings are fixed: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field of the instruction register.
- funct3  in  3  instruction bits 14:12; used only by the Optional Feature.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  0=PC, 1=ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1.
- alu_src_b  out  2  00=RD2, 01=ImmExt, 10=constant 4.
- alu_op  out  2  to the ALU decoder.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J.
- reg_write  out  1  register file write enable.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state  out  4  current state, for debug.

Behaviour:
- Reset: reset_n low forces state=FETCH asynchronously. Outputs are decoded from state (Moore), so during reset only FETCH outputs are driven, all qualified by mem_ready. mem_write=0 immediately, even if reset arrives mid-MEMWRITE.
- Defaults: every output not listed for a state is 0.
- imm_src is pure combinational from op:
  - lw and I-ALU → 00; sw → 01; beq → 10; jal → 11; all other opcodes → 00.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write(PCUpdate) = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - 0000011 (lw) / 0100011 (sw) → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other op → FETCH, with illegal_op=1 for that cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle until mem_ready=1.
  - The cycle with mem_ready=1 also asserts retire=1; the next state is FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, PCUpdate=1, then ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, Branch=1, retire=1, then FETCH.
- pc_write = PCUpdate | (Branch & take). Without the Optional Feature, take=zero.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles. sw: 4. R/I-type: 4. jal: 4. beq: 3. Illegal op: 2.
  - Each memory-state cycle with mem_ready=0 adds one cycle.
- Unreachable state encodings (11–15) go to FETCH on the next clock with all outputs 0.
- op and funct3 must be stable from DECODE through the end of the instruction; ir_write is only asserted in FETCH.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined: the BEQ state serves opcode 1100011 with either funct3. take = zero when funct3=000, take = ~zero when funct3=001. Any other funct3 is reported as illegal_op in DECODE and the FSM returns to FETCH.
- Undefined: take=zero for every funct3, so bne executes as beq.

Test Plan:
- Reset: assert reset_n=0 mid-MEMWRITE with mem_ready=0 → state=0 and mem_write=0 in the same cycle; after release with mem_ready=1, ir_write=1 and pc_write=1.
- R-type: op=0110011, mem_ready=1 → states 0,1,6,8,0; alu_op=10 in state 6; reg_write=1 and retire=1 only in state 8.
- lw with wait states: op=0000011, mem_ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; adr_src=1 throughout MEMREAD; result_src=01 in MEMWB.
- sw: op=0100011, mem_ready=0 then 1 → mem_write=1 for 2 cycles, retire on the second, then FETCH; reg_write never asserted.
- beq: op=1100011, zero=1 → pc_write=1 in state 9; with zero=0 → pc_write=0. In both cases imm_src=10 and retire=1.
- Illegal op and jal: op=1110011 → illegal_op pulse in DECODE, then FETCH after 2 cycles. op=1101111 → states 0,1,10,8 with pc_write=1 in state 10 and imm_src=11.
